// File: rtl/psl_bw_line_assembler_if.sv
// PSL buffer-write beat bus plus the assembled-line valid/ready stream.
// The slave modport is the assembler and the master modport is the PSL side together with
// the line consumer.
interface psl_bw_line_assembler_if;
   logic          ha_bwvalid;
   logic [0:7]    ha_bwtag;
   logic          ha_bwtagpar;
   logic [0:5]    ha_bwad;
   logic [0:511]  ha_bwdata;
   logic [0:7]    ha_bwpar;

   logic          line_valid;
   logic          line_ready;
   logic [0:7]    line_tag;
   logic [0:1023] line_data;
   logic [0:15]   line_par;

   modport master (
      output ha_bwvalid, ha_bwtag, ha_bwtagpar, ha_bwad, ha_bwdata, ha_bwpar, line_ready,
      input  line_valid, line_tag, line_data, line_par
   );

   modport slave (
      input  ha_bwvalid, ha_bwtag, ha_bwtagpar, ha_bwad, ha_bwdata, ha_bwpar, line_ready,
      output line_valid, line_tag, line_data, line_par
   );
endinterface

// File: rtl/psl_bw_line_assembler.sv
// PSL buffer-write line assembler. It pairs 512-bit half-line beats into 1024-bit lines,
// queues the completed lines in a DEPTH-entry FIFO and flags ordering, tag, tag-parity and
// overflow errors in sticky registers.
// Optional macro PSL_BW_DATAPAR_CHECK_EN enables the per-beat data parity check (err_datapar).
module psl_bw_line_assembler #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic                          ha_pclock,
   input  logic                          ha_preset_n,
   psl_bw_line_assembler_if.slave        bw,
   input  logic                          err_clr,
   output logic [CNT_W-1:0]              line_count,
   output logic                          err_seq,
   output logic                          err_tag,
   output logic                          err_tagpar,
   output logic                          err_ovf,
   output logic                          err_datapar
);
   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

   typedef enum logic [0:0] {StIdle, StHalf1} state_e;

   state_e         state_q;
   logic [0:7]     hold_tag_q;
   logic [0:511]   hold_data_q;
   logic [0:7]     hold_par_q;

   logic [0:7]     mem_tag_q  [DEPTH];
   logic [0:1023]  mem_data_q [DEPTH];
   logic [0:15]    mem_par_q  [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;

   logic err_seq_q, err_tag_q, err_tagpar_q, err_ovf_q;
   logic beat_half1, tagpar_bad, seq_bad, line_done, tag_bad;
   logic full, pop, push, ovf;

   // Only bit 5 of the half-line address selects the half.
   logic [4:0] unused_ad;
   assign unused_ad = bw.ha_bwad[0:4];

   // Beat classification, FIFO handshake and error events for this cycle.
   always_comb begin
      beat_half1 = bw.ha_bwad[5];
      tagpar_bad = bw.ha_bwvalid && ((~^bw.ha_bwtag) != bw.ha_bwtagpar);
      seq_bad    = bw.ha_bwvalid && (((state_q == StIdle) && beat_half1) ||
                                     ((state_q == StHalf1) && !beat_half1));
      line_done  = bw.ha_bwvalid && (state_q == StHalf1) && beat_half1;
      tag_bad    = line_done && (bw.ha_bwtag != hold_tag_q);
      full       = (count_q == FullCnt);
      pop        = (count_q != '0) && bw.line_ready;
      // A pop frees the slot, so a full FIFO still accepts a line in the same cycle.
      push       = line_done && (!full || pop);
      ovf        = line_done && full && !pop;
   end

   // Half-ordering FSM. A half-0 beat always (re)starts a line and a half-1 beat always
   // returns to idle, whether it completed a line or was dropped as out of order.
   always_ff @(posedge ha_pclock) begin
      if (!ha_preset_n) begin
         state_q <= StIdle;
      end else if (bw.ha_bwvalid) begin
         case (state_q)
            StIdle:  if (!beat_half1) state_q <= StHalf1;
            StHalf1: if (beat_half1)  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Half-0 holding register. A repeated half-0 beat overwrites the stale half.
   always_ff @(posedge ha_pclock) begin
      if (bw.ha_bwvalid && !beat_half1) begin
         hold_tag_q  <= bw.ha_bwtag;
         hold_data_q <= bw.ha_bwdata;
         hold_par_q  <= bw.ha_bwpar;
      end
   end

   // FIFO storage. A completed line keeps the half-0 tag.
   always_ff @(posedge ha_pclock) begin
      if (push) begin
         mem_tag_q[wr_ptr_q]  <= hold_tag_q;
         mem_data_q[wr_ptr_q] <= {hold_data_q, bw.ha_bwdata};
         mem_par_q[wr_ptr_q]  <= {hold_par_q, bw.ha_bwpar};
      end
   end

   // Occupancy next state.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO pointers and occupancy. DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge ha_pclock) begin
      if (!ha_preset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_d;
      end
   end

   // Sticky errors. A new event wins over err_clr in the same cycle.
   always_ff @(posedge ha_pclock) begin
      if (!ha_preset_n) begin
         err_seq_q    <= 1'b0;
         err_tag_q    <= 1'b0;
         err_tagpar_q <= 1'b0;
         err_ovf_q    <= 1'b0;
      end else begin
         err_seq_q    <= (err_seq_q    && !err_clr) || seq_bad;
         err_tag_q    <= (err_tag_q    && !err_clr) || tag_bad;
         err_tagpar_q <= (err_tagpar_q && !err_clr) || tagpar_bad;
         err_ovf_q    <= (err_ovf_q    && !err_clr) || ovf;
      end
   end

`ifdef PSL_BW_DATAPAR_CHECK_EN
   logic datapar_bad;
   logic err_datapar_q;

   // Odd parity per 64-bit lane of each valid beat.
   always_comb begin
      datapar_bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if ((~^bw.ha_bwdata[64*i +: 64]) != bw.ha_bwpar[i]) datapar_bad = 1'b1;
      end
      datapar_bad = datapar_bad && bw.ha_bwvalid;
   end

   // Sticky data parity error.
   always_ff @(posedge ha_pclock) begin
      if (!ha_preset_n) err_datapar_q <= 1'b0;
      else              err_datapar_q <= (err_datapar_q && !err_clr) || datapar_bad;
   end

   assign err_datapar = err_datapar_q;
`else
   assign err_datapar = 1'b0;
`endif

   assign bw.line_valid = (count_q != '0);
   assign bw.line_tag   = mem_tag_q[rd_ptr_q];
   assign bw.line_data  = mem_data_q[rd_ptr_q];
   assign bw.line_par   = mem_par_q[rd_ptr_q];
   assign line_count    = count_q;
   assign err_seq       = err_seq_q;
   assign err_tag       = err_tag_q;
   assign err_tagpar    = err_tagpar_q;
   assign err_ovf       = err_ovf_q;
endmodule

// File: tb/tb_psl_bw_line_assembler.sv
// Self-checking bench for psl_bw_line_assembler. It uses a vector table for single-line
// transactions, hand-written sequences for overflow, ordering and reset cases, and a
// scoreboard queue that a monitor compares against every popped line.
module tb_psl_bw_line_assembler;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 3;
`ifdef PSL_BW_DATAPAR_CHECK_EN
   localparam logic DparEn = 1'b1;
`else
   localparam logic DparEn = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             err_clr = 1'b0;
   logic [CNT_W-1:0] line_count;
   logic             err_seq, err_tag, err_tagpar, err_ovf, err_datapar;

   psl_bw_line_assembler_if bw ();

   psl_bw_line_assembler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .ha_pclock   (clk),
      .ha_preset_n (rst_n),
      .bw          (bw),
      .err_clr     (err_clr),
      .line_count  (line_count),
      .err_seq     (err_seq),
      .err_tag     (err_tag),
      .err_tagpar  (err_tagpar),
      .err_ovf     (err_ovf),
      .err_datapar (err_datapar)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [0:7]    tag;
      logic [0:1023] data;
      logic [0:15]   par;
   } line_t;

   typedef struct {
      logic [0:7] tag0;
      logic [0:7] tag1;
      int         gap;
      logic       bad_tagpar;
      logic       bad_datapar;
      logic [4:0] exp_err;   // {seq, tag, tagpar, ovf, datapar}
   } vec_t;

   line_t exp_q[$];
   int    n_checks = 0;
   int    n_errors = 0;

   task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h required %h (low 128 bits)", name, act[127:0], exp[127:0]);
      end
   endtask

   function automatic logic [4:0] errs();
      return {err_seq, err_tag, err_tagpar, err_ovf, err_datapar};
   endfunction

   function automatic logic [0:511] rand_half();
      logic [0:511] d;
      for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [0:7] odd_par(input logic [0:511] d);
      logic [0:7] p;
      for (int i = 0; i < 8; i++) p[i] = ~^d[64*i +: 64];
      return p;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one valid beat for exactly one clock and returns 1 time unit after that edge.
   task automatic send_beat(input logic [0:7] tag, input logic half1, input logic [0:511] data,
                            input logic [0:7] par, input logic bad_tagpar);
      bw.ha_bwvalid  = 1'b1;
      bw.ha_bwtag    = tag;
      bw.ha_bwtagpar = (~^tag) ^ bad_tagpar;
      bw.ha_bwad     = {5'b00000, half1};
      bw.ha_bwdata   = data;
      bw.ha_bwpar    = par;
      @(posedge clk);
      #1;
      bw.ha_bwvalid  = 1'b0;
   endtask

   task automatic send_line(input logic [0:7] tag0, input logic [0:7] tag1, input int gap,
                            input logic bad_tagpar, input logic bad_datapar,
                            input logic expect_push);
      logic [0:511] d0, d1;
      logic [0:7]   p0, p1;
      line_t        l;
      d0 = rand_half();
      d1 = rand_half();
      p0 = odd_par(d0);
      p1 = odd_par(d1);
      if (bad_datapar) p1[3] = ~p1[3];
      send_beat(tag0, 1'b0, d0, p0, bad_tagpar);
      idle(gap);
      send_beat(tag1, 1'b1, d1, p1, 1'b0);
      if (expect_push) begin
         l.tag  = tag0;
         l.data = {d0, d1};
         l.par  = {p0, p1};
         exp_q.push_back(l);
      end
   endtask

   task automatic clear_errs();
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
   endtask

   // Bounded wait for the FIFO to empty; the monitor compares the lines as they leave.
   task automatic drain(input string name);
      for (int i = 0; i < 20 && line_count != '0; i++) idle(1);
      check({name, "_count"}, line_count, '0);
      check({name, "_scoreboard"}, exp_q.size(), 0);
   endtask

   // Scoreboard monitor: the head seen at the falling edge is what the next rising edge pops.
   always @(negedge clk) begin
      line_t e;
      if (rst_n && bw.line_valid && bw.line_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_line: got tag %h required no line", bw.line_tag);
         end else begin
            e = exp_q.pop_front();
            check("line_tag", bw.line_tag, e.tag);
            check("line_data", bw.line_data, e.data);
            check("line_par", bw.line_par, e.par);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish required finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t         vecs[6];
      logic [0:511] a, b, c;
      logic [0:7]   pa, pb, pc;
      line_t        l;

      vecs[0] = '{tag0: 8'h21, tag1: 8'h21, gap: 0, bad_tagpar: 0, bad_datapar: 0,
                  exp_err: 5'b00000};
      vecs[1] = '{tag0: 8'h07, tag1: 8'h08, gap: 2, bad_tagpar: 0, bad_datapar: 0,
                  exp_err: 5'b01000};
      vecs[2] = '{tag0: 8'h33, tag1: 8'h33, gap: 0, bad_tagpar: 1, bad_datapar: 0,
                  exp_err: 5'b00100};
      vecs[3] = '{tag0: 8'h44, tag1: 8'h44, gap: 1, bad_tagpar: 0, bad_datapar: 1,
                  exp_err: {4'b0000, DparEn}};
      vecs[4] = '{tag0: 8'hFF, tag1: 8'hFF, gap: 5, bad_tagpar: 0, bad_datapar: 0,
                  exp_err: 5'b00000};
      vecs[5] = '{tag0: 8'h00, tag1: 8'h00, gap: 0, bad_tagpar: 0, bad_datapar: 0,
                  exp_err: 5'b00000};

      bw.ha_bwvalid  = 1'b0;
      bw.ha_bwtag    = '0;
      bw.ha_bwtagpar = 1'b1;
      bw.ha_bwad     = '0;
      bw.ha_bwdata   = '0;
      bw.ha_bwpar    = '0;
      bw.line_ready  = 1'b0;

      // Reset
      idle(3);
      rst_n = 1'b1;
      check("reset_valid", bw.line_valid, 1'b0);
      check("reset_count", line_count, '0);
      check("reset_errs", errs(), 5'b00000);

      // Basic line: one cycle latency from the half-1 beat
      a  = rand_half();
      b  = rand_half();
      pa = odd_par(a);
      pb = odd_par(b);
      send_beat(8'h12, 1'b0, a, pa, 1'b0);
      check("half0_no_valid", bw.line_valid, 1'b0);
      send_beat(8'h12, 1'b1, b, pb, 1'b0);
      check("basic_valid", bw.line_valid, 1'b1);
      check("basic_tag", bw.line_tag, 8'h12);
      check("basic_data", bw.line_data, {a, b});
      check("basic_count", line_count, 3'd1);
      check("basic_errs", errs(), 5'b00000);
      l.tag  = 8'h12;
      l.data = {a, b};
      l.par  = {pa, pb};
      exp_q.push_back(l);
      bw.line_ready = 1'b1;
      drain("basic");

      // Table-driven single-line transactions
      for (int i = 0; i < 6; i++) begin
         send_line(vecs[i].tag0, vecs[i].tag1, vecs[i].gap, vecs[i].bad_tagpar,
                   vecs[i].bad_datapar, 1'b1);
         idle(2);
         check($sformatf("vec%0d_errs", i), errs(), vecs[i].exp_err);
         clear_errs();
         check($sformatf("vec%0d_errs_cleared", i), errs(), 5'b00000);
      end
      drain("vec");

      // Overflow: five lines into four entries with no consumer
      bw.line_ready = 1'b0;
      for (int i = 0; i < 5; i++) send_line(8'(i + 1), 8'(i + 1), 0, 1'b0, 1'b0, i < 4);
      check("ovf_count", line_count, 3'd4);
      check("ovf_errs", errs(), 5'b00010);
      bw.line_ready = 1'b1;
      drain("ovf");
      clear_errs();
      check("ovf_cleared", errs(), 5'b00000);

      // err_clr in the same cycle as a new ordering error keeps the error
      err_clr = 1'b1;
      c = rand_half();
      send_beat(8'h66, 1'b1, c, odd_par(c), 1'b0);
      err_clr = 1'b0;
      check("clr_vs_event", errs(), 5'b10000);
      clear_errs();

      // Half-1 first, then a proper pair
      c = rand_half();
      send_beat(8'h09, 1'b1, c, odd_par(c), 1'b0);
      send_line(8'h05, 8'h05, 0, 1'b0, 1'b0, 1'b1);
      idle(2);
      check("seq_h1_first_errs", errs(), 5'b10000);
      drain("seq_h1_first");
      clear_errs();

      // Two half-0 beats: the second replaces the first
      a  = rand_half();
      b  = rand_half();
      c  = rand_half();
      pb = odd_par(b);
      pc = odd_par(c);
      send_beat(8'h0A, 1'b0, a, odd_par(a), 1'b0);
      send_beat(8'h0B, 1'b0, b, pb, 1'b0);
      send_beat(8'h0B, 1'b1, c, pc, 1'b0);
      l.tag  = 8'h0B;
      l.data = {b, c};
      l.par  = {pb, pc};
      exp_q.push_back(l);
      idle(2);
      check("seq_h0_twice_errs", errs(), 5'b10000);
      drain("seq_h0_twice");
      clear_errs();

      // Reset between halves drops the captured half
      a = rand_half();
      b = rand_half();
      send_beat(8'h31, 1'b0, a, odd_par(a), 1'b0);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      send_beat(8'h31, 1'b1, b, odd_par(b), 1'b0);
      idle(2);
      check("rst_mid_valid", bw.line_valid, 1'b0);
      check("rst_mid_count", line_count, '0);
      check("rst_mid_errs", errs(), 5'b10000);
      clear_errs();

      // Full FIFO with a push and a pop in the same cycle
      bw.line_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_line(8'(8'h80 + i), 8'(8'h80 + i), 0, 1'b0, 1'b0, 1'b1);
      a  = rand_half();
      b  = rand_half();
      pa = odd_par(a);
      pb = odd_par(b);
      send_beat(8'h55, 1'b0, a, pa, 1'b0);
      check("full_count", line_count, 3'd4);
      bw.line_ready = 1'b1;
      send_beat(8'h55, 1'b1, b, pb, 1'b0);
      l.tag  = 8'h55;
      l.data = {a, b};
      l.par  = {pa, pb};
      exp_q.push_back(l);
      check("full_pushpop_count", line_count, 3'd4);
      check("full_pushpop_errs", errs(), 5'b00000);
      drain("full_pushpop");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/psl_bw_line_assembler.md
Name: psl_bw_line_assembler

Overview:
AFU-side consumer of the PSL buffer-write interface. Takes the 512-bit half-line beats (ha_bwvalid/ha_bwtag/ha_bwad/ha_bwdata/ha_bwpar) and reassembles them into full 1024-bit cache lines tagged by ha_bwtag. Completed lines are queued in a small FIFO and presented to AFU logic through a valid/ready handshake. Checks tag parity, tag consistency across halves and half ordering.

Parameters:
DEPTH, 4, number of assembled-line FIFO entries (power of 2, 2..16)
CNT_W, 3, width of line_count output (must hold DEPTH)

Ports:
ha_pclock  in  1  PSL clock; all logic on posedge
ha_preset_n  in  1  synchronous active-low reset
ha_bwvalid  in  1  write-buffer beat valid
ha_bwtag  in  [0:7]  command tag of beat
ha_bwtagpar  in  1  odd parity over ha_bwtag
ha_bwad  in  [0:5]  half-line address; only bit 5 used (0 = bytes 0-63, 1 = bytes 64-127)
ha_bwdata  in  [0:511]  half-line data
ha_bwpar  in  [0:7]  odd parity, bit i covers ha_bwdata[64i:64i+63]
line_valid  out  1  assembled line available at FIFO head
line_ready  in  1  consumer accepts head line
line_tag  out  [0:7]  tag of head line
line_data  out  [0:1023]  head line; [0:511] = half 0, [512:1023] = half 1
line_par  out  [0:15]  {half-0 parity, half-1 parity}
line_count  out  CNT_W  FIFO occupancy
err_seq  out  1  sticky: half-ordering violation
err_tag  out  1  sticky: tag mismatch between halves
err_tagpar  out  1  sticky: bad ha_bwtagpar
err_ovf  out  1  sticky: line completed while FIFO full and not popping
err_datapar  out  1  sticky: bad data parity (0 without feature)
err_clr  in  1  clears all sticky errors

Behaviour:
- Reset (ha_preset_n=0 at posedge): FSM to IDLE, FIFO empty, line_valid=0, line_count=0, all err_*=0, partial line discarded. line_tag/line_data/line_par undefined while line_valid=0 (bench must not check). Reset mid-line drops the half captured.
- FSM IDLE: beat with ha_bwad[5]=0 -> capture data/par/tag into half-0 holding reg, go HALF1. Beat with ha_bwad[5]=1 -> set err_seq, drop beat, stay IDLE.
- FSM HALF1: beat with ha_bwad[5]=1 -> complete line, push to FIFO, go IDLE. If ha_bwtag differs from held tag, set err_tag; line still pushed with half-0 tag. Beat with ha_bwad[5]=0 -> set err_seq, discard held half, capture new beat as half 0, stay HALF1.
- Beats with ha_bwvalid=0 never change state; gaps of any length between halves allowed.
- Tag parity checked on every valid beat: ~^ha_bwtag != ha_bwtagpar -> err_tagpar; beat still processed.
- Push latency: line_valid rises the cycle after the half-1 beat when FIFO was empty (1-cycle latency). Head outputs registered from FIFO storage.
- Pop: line_valid & line_ready at posedge removes head; next entry visible next cycle.
- Full: push with line_count==DEPTH and no pop same cycle -> line dropped, err_ovf set, FIFO unchanged. Push and pop same cycle when full -> both succeed, count stays DEPTH.
- Simultaneous push/pop otherwise: count unchanged. Pointers wrap modulo DEPTH.
- Sticky errors: set on event, held until err_clr=1; err_clr and new event in same cycle -> error remains set.
- No backpressure to PSL; block must accept a beat every cycle.

Optional Feature:
PSL_BW_DATAPAR_CHECK_EN: when defined, each valid beat checks 8 odd-parity bits (~^ha_bwdata[64i:64i+63] vs ha_bwpar[i]); any mismatch sets err_datapar; beat still processed. When undefined, err_datapar tied 0 and no parity trees synthesised; line_par still passed through.

Test Plan:
- Reset, then beats tag 0x12 bwad=0x00 data A, bwad=0x01 data B, correct parity -> one cycle later line_valid=1, line_tag=0x12, line_data={A,B}, line_count=1, all errs 0.
- line_ready=0, push 5 lines with DEPTH=4 -> line_count=4, err_ovf=1, popping yields lines 1-4 in order; err_clr=1 clears err_ovf.
- Half-1 beat first (bwad=0x01) then proper pair tag 0x05 -> err_seq=1, exactly one line with tag 0x05.
- Half-0 tag 0x07, half-1 tag 0x08 -> err_tag=1, line_tag=0x07.
- Beat with ha_bwtagpar inverted -> err_tagpar=1; with macro defined, flip ha_bwpar[3] -> err_datapar=1, without macro err_datapar=0.
- Half 0 captured, reset asserted one cycle, then half 1 only -> no line, err_seq=1; FIFO full with line_ready=1 and simultaneous push -> count stays 4, no err_ovf.
